surf_dout_frame_arbiter: RTL and testbench
==========================================

// Module: surf_dout_frame_arbiter
// PURPOSE
//  Frame-level round-robin arbiter merging the NSURF per-SURF sysclk datapath streams into one
//  byte stream for the TURF-bound event path. Whole frames (ending on tlast) are never interleaved.
//  Per-SURF enable mask; a stalled source is aborted by timeout, and its frame is closed with an error beat.
// PARAMETERS
//  NSURF       7     number of SURF input streams (1..8)
//  DW          8     stream data width
//  TIMEOUT     1024  mid-frame idle cycles (granted tvalid low) before abort; >=2
// PORTS
//  sysclk_i       in   1          system clock (sole clock)
//  rstn_i         in   1          asynchronous active-low reset
//  s_tdata        in   NSURF*DW   SURF i data at [DW*i +: DW]
//  s_tvalid       in   NSURF      per-SURF valid
//  s_tlast        in   NSURF      per-SURF end of frame
//  s_tready       out  NSURF      per-SURF ready
//  enable_i       in   NSURF      SURF i may be granted; sampled only at grant time / in FLUSH
//  m_tdata        out  DW         merged data
//  m_tvalid       out  1          merged valid
//  m_tlast        out  1          merged end of frame
//  m_tuser        out  4          [2:0] source index of beat, [3] abort (error) beat
//  m_tready       in   1          downstream ready
//  grant_o        out  3          currently/last granted SURF index
//  busy_o         out  1          high in XFER or FLUSH
//  frame_count_o  out  32         frames completed normally (wraps)
//  abort_count_o  out  16         frames aborted by timeout (saturates at 0xFFFF)
// BEHAVIOUR
//  Reset (rstn_i low, async): state=IDLE, ptr=NSURF-1, grant_o=0, m_tvalid=0, m_tdata=0, m_tlast=0,
//   m_tuser=0, s_tready=0, busy_o=0, both counters 0, idle timer 0. Reset mid-frame drops the frame.
//  Output stage: single register; loads when ld = !m_tvalid || m_tready; m_tvalid clears on
//   m_tready with nothing new to load. Input->output latency 1 cycle. Full throughput (1 beat/cycle).
//  s_tready[i] = (i==grant) && ((XFER && ld) || FLUSH); all other bits 0. s_tready is not gated by s_tvalid.
//  IDLE: search i = ptr+1, ptr+2, ... mod NSURF (ptr last) for first s_tvalid[i] && enable_i[i];
//   on hit: grant<=i, ptr<=i, timer<=0, ->XFER. No beat is accepted in IDLE (1 cycle grant bubble).
//  XFER: on s_tvalid[g]&&s_tready[g]: load {data, tlast, tuser={0,g}}, timer<=0; if tlast:
//   frame_count++ , ->IDLE. Cycle with s_tvalid[g]=0: timer++. Cycle with ld=0 (backpressure): timer holds.
//   timer==TIMEOUT-1 and s_tvalid[g]=0 and ld: load abort beat {data=0, tlast=1, tuser={1,g}},
//   abort_count++ (sat), ->FLUSH. enable_i changes do not affect XFER.
//  FLUSH: s_tready[g]=1, beats discarded (never reach m_*). Exit ->IDLE on accepted beat with
//   s_tlast[g]=1, or on enable_i[g]=0 (same cycle, beat discarded). Counters unchanged.
//  Simultaneous: tlast beat and timeout same cycle -> beat wins (no abort). Search after
//   frame/abort starts at g+1, so a continuously valid source cannot win twice while others wait.
//  enable_i=0 for all -> stays IDLE, s_tready=0. Non-enabled sources are never drained.
//  NSURF<8: grant/tuser index width fixed at 3 bits, unused codes never produced.
// TESTING
//  1 Reset, all 7 sources hold 4-beat frames valid -> grants 0,1,...,6,0; m_tuser[2:0] follows;
//    no interleave; frame_count_o=7 after first round; one bubble per frame.
//  2 m_tready toggled 50% random, src 3 only, 100-beat frame -> bytes in order, none lost/duplicated,
//    m_tlast only on beat 100, timer never fires despite stalls.
//  3 TIMEOUT=16, src 2 sends 3 beats then drops tvalid -> exactly 16 idle cycles later abort beat
//    {0x00, tlast=1, tuser=0xA}; abort_count_o=1; later 5 beats+tlast from src 2 discarded; IDLE.
//  4 enable_i=7'b1111011 with src 2 valid continuously -> src 2 never granted, s_tready[2]=0;
//    clear enable_i[1] mid-frame of src 1 -> frame completes normally.
//  5 Assert rstn_i low mid-frame for 1 cycle -> all outputs at reset values immediately;
//    after release, grant begins at src 0.
//  6 Frame of 1 beat (tlast on first beat) on src 5 coinciding with timer==TIMEOUT-1 -> normal
//    frame, frame_count_o++, abort_count_o unchanged.

Source files
------------

// File: rtl/surf_dout_frame_arbiter_if.sv
// Bus bundle for surf_dout_frame_arbiter.
// Carries the NSURF per-SURF input streams (s_*) and the merged output
// stream (m_*).
//   slave  : the arbiter's view. It sinks the s_* streams and sources m_*.
//   master : the environment's view. It drives the SURF streams and sinks
//            the merged stream.
// Signals:
//   s_tdata  [NSURF*DW]  SURF i data at [DW*i +: DW]
//   s_tvalid [NSURF]     per-SURF valid
//   s_tlast  [NSURF]     per-SURF end of frame
//   s_tready [NSURF]     per-SURF ready
//   m_tdata  [DW]        merged data
//   m_tvalid             merged valid
//   m_tlast              merged end of frame
//   m_tuser  [4]         [2:0] source index of the beat, [3] abort (error) beat
//   m_tready             downstream ready
interface surf_dout_frame_arbiter_if #(
   parameter int NSURF = 7,
   parameter int DW    = 8
);
   logic [NSURF*DW-1:0] s_tdata;
   logic [NSURF-1:0]    s_tvalid;
   logic [NSURF-1:0]    s_tlast;
   logic [NSURF-1:0]    s_tready;
   logic [DW-1:0]       m_tdata;
   logic                m_tvalid;
   logic                m_tlast;
   logic [3:0]          m_tuser;
   logic                m_tready;

   modport slave (
      input  s_tdata, s_tvalid, s_tlast,
      output s_tready,
      output m_tdata, m_tvalid, m_tlast, m_tuser,
      input  m_tready
   );

   modport master (
      output s_tdata, s_tvalid, s_tlast,
      input  s_tready,
      input  m_tdata, m_tvalid, m_tlast, m_tuser,
      output m_tready
   );
endinterface

// File: rtl/surf_dout_frame_arbiter.sv
// Frame-level round-robin arbiter. It merges the per-SURF sysclk streams into
// one byte stream for the TURF-bound event path. Whole frames are never
// interleaved. A granted source that stalls mid-frame for TIMEOUT cycles is
// aborted: its frame is closed with an error beat, and the remainder of its
// frame is flushed.
// Ports:
//   sysclk_i       system clock (sole clock)
//   rstn_i         asynchronous active-low reset
//   bus            stream bundle (slave modport): s_* inputs, m_* output
//   enable_i       SURF i may be granted; sampled at grant time and in FLUSH
//   grant_o        currently or last granted SURF index
//   busy_o         high while transferring or flushing a frame
//   frame_count_o  frames completed normally (wraps)
//   abort_count_o  frames aborted by timeout (saturates)
module surf_dout_frame_arbiter #(
   parameter int NSURF   = 7,
   parameter int DW      = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic                     sysclk_i,
   input  logic                     rstn_i,
   surf_dout_frame_arbiter_if.slave bus,
   input  logic [NSURF-1:0]         enable_i,
   output logic [2:0]               grant_o,
   output logic                     busy_o,
   output logic [31:0]              frame_count_o,
   output logic [15:0]              abort_count_o
);

   localparam int             TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [2:0]     PTR_RESET  = 3'(NSURF - 1);

   typedef enum logic [1:0] {IDLE, XFER, FLUSH} state_t;

   state_t        state, state_n;
   logic [2:0]    ptr, ptr_n;
   logic [2:0]    grant, grant_n;
   logic [TW-1:0] timer, timer_n;
   logic [31:0]   frame_cnt, frame_cnt_n;
   logic [15:0]   abort_cnt, abort_cnt_n;
   logic [DW-1:0] m_data_q, m_data_n;
   logic          m_valid_q, m_valid_n;
   logic          m_last_q, m_last_n;
   logic [3:0]    m_user_q, m_user_n;

   logic             ld;
   logic [NSURF-1:0] req;
   logic             hit;
   logic [2:0]       hit_idx;
   logic             g_valid, g_last, g_en;
   logic [DW-1:0]    g_data;

   // The output register can take a new beat when it is empty or draining this cycle.
   assign ld = !m_valid_q || bus.m_tready;

   // Round-robin search: indices above ptr first, then wrap to 0..ptr, so the
   // last-served source has the lowest priority.
   // NOTE: every variable written in an always_comb gets a default at the top of the block; a path that leaves one unassigned would infer a latch.
   always_comb begin
      req     = bus.s_tvalid & enable_i;
      hit     = 1'b0;
      hit_idx = 3'd0;
      for (int i = 0; i < NSURF; i++) begin
         if (!hit && req[i] && (3'(i) > ptr)) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
      end
      for (int i = 0; i < NSURF; i++) begin
         if (!hit && req[i] && (3'(i) <= ptr)) begin
            hit     = 1'b1;
            hit_idx = 3'(i);
         end
      end
   end

   // Select the granted source's stream.
   always_comb begin
      g_valid = 1'b0;
      g_last  = 1'b0;
      g_en    = 1'b0;
      g_data  = '0;
      for (int i = 0; i < NSURF; i++) begin
         if (grant == 3'(i)) begin
            g_valid = bus.s_tvalid[i];
            g_last  = bus.s_tlast[i];
            g_en    = enable_i[i];
            g_data  = bus.s_tdata[DW*i +: DW];
         end
      end
   end

   // The ready signal does not depend on s_tvalid. FLUSH drains the source regardless of the output stage.
   always_comb begin
      bus.s_tready = '0;
      for (int i = 0; i < NSURF; i++) begin
         if ((grant == 3'(i)) && (((state == XFER) && ld) || (state == FLUSH)))
            bus.s_tready[i] = 1'b1;
      end
   end

   always_comb begin
      state_n     = state;
      ptr_n       = ptr;
      grant_n     = grant;
      timer_n     = timer;
      frame_cnt_n = frame_cnt;
      abort_cnt_n = abort_cnt;
      m_data_n    = m_data_q;
      m_last_n    = m_last_q;
      m_user_n    = m_user_q;
      m_valid_n   = m_valid_q;
      // The current beat is consumed (or the slot was already empty). The beat stays valid only if it is reloaded below.
      if (ld)
         m_valid_n = 1'b0;

      unique case (state)
         IDLE: begin
            // No beat is accepted in this cycle. The grant costs one bubble per frame.
            if (hit) begin
               grant_n = hit_idx;
               ptr_n   = hit_idx;
               timer_n = '0;
               state_n = XFER;
            end
         end

         XFER: begin
            if (ld) begin
               if (g_valid) begin
                  // A real beat always beats a coincident timeout.
                  m_valid_n = 1'b1;
                  m_data_n  = g_data;
                  m_last_n  = g_last;
                  m_user_n  = {1'b0, grant};
                  timer_n   = '0;
                  if (g_last) begin
                     frame_cnt_n = frame_cnt + 32'd1;
                     state_n     = IDLE;
                  end
               end else if (timer == TIMER_LAST) begin
                  m_valid_n = 1'b1;
                  m_data_n  = '0;
                  m_last_n  = 1'b1;
                  m_user_n  = {1'b1, grant};
                  if (abort_cnt != 16'hFFFF)
                     abort_cnt_n = abort_cnt + 16'd1;
                  state_n = FLUSH;
               end else begin
                  timer_n = timer + TW'(1);
               end
            end
            // With backpressure (ld low) the timer holds, because a stall is not the source's fault.
         end

         FLUSH: begin
            // Beats are discarded. Disabling the source also ends the flush.
            if (!g_en || (g_valid && g_last))
               state_n = IDLE;
         end

         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values, independent of statement order.
   always_ff @(posedge sysclk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state     <= IDLE;
         ptr       <= PTR_RESET;
         grant     <= 3'd0;
         timer     <= '0;
         frame_cnt <= '0;
         abort_cnt <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_user_q  <= '0;
      end else begin
         state     <= state_n;
         ptr       <= ptr_n;
         grant     <= grant_n;
         timer     <= timer_n;
         frame_cnt <= frame_cnt_n;
         abort_cnt <= abort_cnt_n;
         m_data_q  <= m_data_n;
         m_valid_q <= m_valid_n;
         m_last_q  <= m_last_n;
         m_user_q  <= m_user_n;
      end
   end

   assign bus.m_tdata   = m_data_q;
   assign bus.m_tvalid  = m_valid_q;
   assign bus.m_tlast   = m_last_q;
   assign bus.m_tuser   = m_user_q;
   assign grant_o       = grant;
   assign busy_o        = (state != IDLE);
   assign frame_count_o = frame_cnt;
   assign abort_count_o = abort_cnt;

endmodule

// File: tb/tb_surf_dout_frame_arbiter.sv
module tb_surf_dout_frame_arbiter;

   localparam int NS = 7;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [6:0]  enable;
   logic [2:0]  grant;
   logic        busy;
   logic [31:0] frame_count;
   logic [15:0] abort_count;

   surf_dout_frame_arbiter_if #(.NSURF(NS), .DW(8)) bus ();

   surf_dout_frame_arbiter #(.NSURF(NS), .DW(8), .TIMEOUT(16)) dut (
      .sysclk_i      (clk),
      .rstn_i        (rstn),
      .bus           (bus),
      .enable_i      (enable),
      .grant_o       (grant),
      .busy_o        (busy),
      .frame_count_o (frame_count),
      .abort_count_o (abort_count)
   );

   always #5 clk = ~clk;

   // Source model: src_frames[i] frames of src_len[i] beats, data = base + beat.
   int         src_len [NS];
   int         src_frames [NS];
   int         src_beat [NS];
   logic [7:0] src_base [NS];
   logic [6:0] gate;
   logic [6:0] acc;
   logic [6:0] ready_seen;
   int         cyc;

   logic [7:0]  ob_data [$];
   logic [3:0]  ob_user [$];
   logic        ob_last [$];
   int          ob_cyc [$];
   logic [31:0] ob_fc [$];

   int total = 0;
   int bad   = 0;

   task automatic drive();
      for (int i = 0; i < NS; i++) begin
         bus.s_tvalid[i]          = (src_frames[i] > 0) && gate[i];
         bus.s_tdata[8*i +: 8]    = src_base[i] + 8'(src_beat[i]);
         bus.s_tlast[i]           = (src_beat[i] == src_len[i] - 1);
      end
   endtask

   // Starts just after a negedge, ends on the next negedge.
   task automatic step();
      drive();
      #1;
      acc        = bus.s_tvalid & bus.s_tready;
      ready_seen = ready_seen | bus.s_tready;
      if (bus.m_tvalid && bus.m_tready) begin
         ob_data.push_back(bus.m_tdata);
         ob_user.push_back(bus.m_tuser);
         ob_last.push_back(bus.m_tlast);
         ob_cyc.push_back(cyc);
         ob_fc.push_back(frame_count);
      end
      @(posedge clk);
      for (int i = 0; i < NS; i++) begin
         if (acc[i]) begin
            src_beat[i]++;
            if (src_beat[i] == src_len[i]) begin
               src_beat[i] = 0;
               src_frames[i]--;
            end
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < NS; i++) begin
         src_len[i]    = 1;
         src_frames[i] = 0;
         src_beat[i]   = 0;
         src_base[i]   = 8'h00;
      end
      gate = '0;
      ob_data.delete();
      ob_user.delete();
      ob_last.delete();
      ob_cyc.delete();
      ob_fc.delete();
      ready_seen = '0;
      cyc = 0;
   endtask

   task automatic do_reset();
      rstn         = 1'b0;
      enable       = '1;
      bus.m_tready = 1'b1;
      clear_model();
      drive();
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      rstn = 1'b0;
      #1;
      total++; if (bus.m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_m_tvalid got=%0b want=0", bus.m_tvalid); end
      total++; if (bus.s_tready !== 7'h00) begin bad++; $display("FAIL reset_s_tready got=%b want=0000000", bus.s_tready); end
      total++; if ({busy, grant} !== 4'h0) begin bad++; $display("FAIL reset_busy_grant got=%b want=0000", {busy, grant}); end
      @(negedge clk);
      rstn = 1'b1;
      // No source enabled: nothing may be granted or drained.
      enable = '0;
      src_frames[0] = 1; src_len[0] = 2; gate = '1;
      repeat (6) step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL no_enable_busy got=%0b want=0", busy); end
      total++; if (ready_seen !== 7'h00) begin bad++; $display("FAIL no_enable_ready got=%b want=0000000", ready_seen); end
      total++; if (ob_data.size() != 0) begin bad++; $display("FAIL no_enable_out got=%0d want=0", ob_data.size()); end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < NS; i++) begin
         src_len[i]    = 4;
         src_frames[i] = (i == 0) ? 2 : 1;
         src_base[i]   = 8'(i * 16);
      end
      gate = '1;
      for (int n = 0; n < 100 && ob_data.size() < 32; n++) step();
      repeat (3) step();
      total++; if (ob_data.size() != 32) begin bad++; $display("FAIL rr_beats got=%0d want=32", ob_data.size()); end
      if (ob_data.size() == 32) begin
         for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 4; b++) begin
               int k;
               logic [7:0] ed;
               k  = f * 4 + b;
               ed = 8'((f % 7) * 16 + b);
               total++; if (ob_user[k] !== 4'(f % 7)) begin bad++; $display("FAIL rr_user f=%0d b=%0d got=%h want=%h", f, b, ob_user[k], 4'(f % 7)); end
               total++; if (ob_data[k] !== ed) begin bad++; $display("FAIL rr_data f=%0d b=%0d got=%h want=%h", f, b, ob_data[k], ed); end
               total++; if (ob_last[k] !== (b == 3)) begin bad++; $display("FAIL rr_last f=%0d b=%0d got=%0b want=%0b", f, b, ob_last[k], (b == 3)); end
            end
            total++; if (ob_cyc[f*4+3] - ob_cyc[f*4] != 3) begin bad++; $display("FAIL rr_throughput f=%0d got=%0d want=3", f, ob_cyc[f*4+3] - ob_cyc[f*4]); end
            if (f < 7) begin
               total++; if (ob_cyc[f*4+4] - ob_cyc[f*4+3] != 2) begin bad++; $display("FAIL rr_bubble f=%0d got=%0d want=2", f, ob_cyc[f*4+4] - ob_cyc[f*4+3]); end
            end
         end
         total++; if (ob_fc[27] !== 32'd7) begin bad++; $display("FAIL rr_count_round got=%0d want=7", ob_fc[27]); end
      end
      total++; if (frame_count !== 32'd8) begin bad++; $display("FAIL rr_count_final got=%0d want=8", frame_count); end
   endtask

   task automatic test_backpressure();
      do_reset();
      src_len[3] = 100; src_frames[3] = 1; src_base[3] = 8'h00;
      for (int n = 0; n < 1500 && ob_data.size() < 100; n++) begin
         gate[3]      = (cyc % 4 != 3);
         bus.m_tready = 1'($urandom_range(0, 1));
         step();
      end
      bus.m_tready = 1'b1;
      repeat (5) step();
      total++; if (ob_data.size() != 100) begin bad++; $display("FAIL bp_beats got=%0d want=100", ob_data.size()); end
      if (ob_data.size() == 100) begin
         for (int k = 0; k < 100; k++) begin
            total++; if (ob_data[k] !== 8'(k) || ob_user[k] !== 4'h3) begin bad++; $display("FAIL bp_beat k=%0d got=%h/%h want=%h/3", k, ob_data[k], ob_user[k], 8'(k)); end
            total++; if (ob_last[k] !== (k == 99)) begin bad++; $display("FAIL bp_last k=%0d got=%0b want=%0b", k, ob_last[k], (k == 99)); end
         end
      end
      total++; if (abort_count !== 16'd0) begin bad++; $display("FAIL bp_abort got=%0d want=0", abort_count); end
      total++; if (frame_count !== 32'd1) begin bad++; $display("FAIL bp_frames got=%0d want=1", frame_count); end
   endtask

   task automatic test_timeout();
      int n0;
      n0 = -100;
      do_reset();
      src_len[2] = 100; src_frames[2] = 1; src_base[2] = 8'h20;
      for (int n = 0; n < 200 && ob_data.size() < 4; n++) begin
         int c;
         c = cyc;
         gate[2] = (src_beat[2] < 3);
         step();
         if (acc[2] && src_beat[2] == 3) n0 = c;
      end
      total++; if (ob_data.size() != 4) begin bad++; $display("FAIL to_beats got=%0d want=4", ob_data.size()); end
      if (ob_data.size() == 4) begin
         total++; if (ob_data[2] !== 8'h22 || ob_last[2] !== 1'b0) begin bad++; $display("FAIL to_beat3 got=%h/%0b want=22/0", ob_data[2], ob_last[2]); end
         total++; if ({ob_data[3], ob_last[3], ob_user[3]} !== {8'h00, 1'b1, 4'hA}) begin bad++; $display("FAIL to_abort_beat got=%h/%0b/%h want=00/1/a", ob_data[3], ob_last[3], ob_user[3]); end
         total++; if (ob_cyc[3] != n0 + 17) begin bad++; $display("FAIL to_abort_time got=%0d want=%0d", ob_cyc[3], n0 + 17); end
      end
      total++; if (abort_count !== 16'd1) begin bad++; $display("FAIL to_abort_count got=%0d want=1", abort_count); end
      drive();
      #1;
      total++; if (bus.s_tready !== 7'b0000100 || busy !== 1'b1) begin bad++; $display("FAIL to_flush_ready got=%b busy=%0b want=0000100 busy=1", bus.s_tready, busy); end
      @(negedge clk);
      src_len[2] = 5; src_beat[2] = 0; src_frames[2] = 1; gate[2] = 1'b1;
      for (int n = 0; n < 20 && src_frames[2] > 0; n++) step();
      repeat (2) step();
      total++; if (src_frames[2] != 0) begin bad++; $display("FAIL to_flush_drain got=%0d want=0", src_frames[2]); end
      total++; if (ob_data.size() != 4) begin bad++; $display("FAIL to_flush_discard got=%0d want=4", ob_data.size()); end
      total++; if ({busy, frame_count, abort_count} !== {1'b0, 32'd0, 16'd1}) begin bad++; $display("FAIL to_flush_end got=%0b/%0d/%0d want=0/0/1", busy, frame_count, abort_count); end
   endtask

   task automatic test_enable_mask();
      do_reset();
      enable = 7'b1111011;
      src_len[2] = 2; src_frames[2] = 3; src_base[2] = 8'h30;
      src_len[1] = 6; src_frames[1] = 1; src_base[1] = 8'h40;
      gate = '1;
      for (int n = 0; n < 40; n++) begin
         if (src_frames[1] > 0 && src_beat[1] == 2) enable[1] = 1'b0;
         step();
      end
      total++; if (ready_seen[2] !== 1'b0) begin bad++; $display("FAIL en_ready2 got=%0b want=0", ready_seen[2]); end
      total++; if (src_frames[2] != 3) begin bad++; $display("FAIL en_src2_drained got=%0d want=3", src_frames[2]); end
      total++; if (ob_data.size() != 6) begin bad++; $display("FAIL en_beats got=%0d want=6", ob_data.size()); end
      if (ob_data.size() == 6) begin
         for (int k = 0; k < 6; k++) begin
            total++; if ({ob_data[k], ob_user[k], ob_last[k]} !== {8'(8'h40 + k), 4'h1, (k == 5)}) begin bad++; $display("FAIL en_beat k=%0d got=%h/%h/%0b want=%h/1/%0b", k, ob_data[k], ob_user[k], ob_last[k], 8'(8'h40 + k), (k == 5)); end
         end
      end
      total++; if (frame_count !== 32'd1 || busy !== 1'b0) begin bad++; $display("FAIL en_end got=%0d/%0b want=1/0", frame_count, busy); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      src_len[1] = 1;  src_frames[1] = 1; src_base[1] = 8'h50;
      src_len[4] = 10; src_frames[4] = 1; src_base[4] = 8'h60;
      gate = '1;
      for (int n = 0; n < 40 && src_beat[4] != 3; n++) step();
      total++; if (frame_count !== 32'd1 || grant !== 3'd4 || bus.m_tvalid !== 1'b1) begin bad++; $display("FAIL mr_pre got=%0d/%0d/%0b want=1/4/1", frame_count, grant, bus.m_tvalid); end
      rstn = 1'b0;
      #1;
      total++; if ({bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.m_tuser} !== 14'h0) begin bad++; $display("FAIL mr_out got=%0b/%h/%0b/%h want=0/00/0/0", bus.m_tvalid, bus.m_tdata, bus.m_tlast, bus.m_tuser); end
      total++; if ({bus.s_tready, busy, grant} !== 11'h0) begin bad++; $display("FAIL mr_ctl got=%b/%0b/%0d want=0/0/0", bus.s_tready, busy, grant); end
      total++; if (frame_count !== 32'd0 || abort_count !== 16'd0) begin bad++; $display("FAIL mr_counts got=%0d/%0d want=0/0", frame_count, abort_count); end
      @(negedge clk);
      rstn = 1'b1;
      clear_model();
      src_len[0] = 2; src_frames[0] = 1; src_base[0] = 8'h70;
      src_len[4] = 2; src_frames[4] = 1; src_base[4] = 8'h60;
      gate = '1;
      for (int n = 0; n < 30 && ob_data.size() < 4; n++) step();
      total++; if (ob_data.size() != 4) begin bad++; $display("FAIL mr_beats got=%0d want=4", ob_data.size()); end
      if (ob_data.size() == 4) begin
         total++; if (ob_user[0] !== 4'h0 || ob_data[0] !== 8'h70) begin bad++; $display("FAIL mr_first got=%h/%h want=0/70", ob_user[0], ob_data[0]); end
         total++; if (ob_user[2] !== 4'h4 || ob_data[2] !== 8'h60) begin bad++; $display("FAIL mr_second got=%h/%h want=4/60", ob_user[2], ob_data[2]); end
      end
   endtask

   task automatic test_tlast_vs_timeout();
      do_reset();
      src_len[5] = 1; src_frames[5] = 1; src_base[5] = 8'h5A;
      gate[5] = 1'b1;
      step();
      total++; if (grant !== 3'd5 || busy !== 1'b1) begin bad++; $display("FAIL tt_grant got=%0d/%0b want=5/1", grant, busy); end
      gate[5] = 1'b0;
      repeat (15) step();
      gate[5] = 1'b1;
      step();
      gate[5] = 1'b0;
      repeat (3) step();
      total++; if (ob_data.size() != 1) begin bad++; $display("FAIL tt_beats got=%0d want=1", ob_data.size()); end
      if (ob_data.size() == 1) begin
         total++; if ({ob_data[0], ob_user[0], ob_last[0]} !== {8'h5A, 4'h5, 1'b1}) begin bad++; $display("FAIL tt_beat got=%h/%h/%0b want=5a/5/1", ob_data[0], ob_user[0], ob_last[0]); end
      end
      total++; if (frame_count !== 32'd1 || abort_count !== 16'd0) begin bad++; $display("FAIL tt_counts got=%0d/%0d want=1/0", frame_count, abort_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL tt_idle got=%0b want=0", busy); end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      enable = '1;
      bus.m_tready = 1'b1;
      clear_model();
      drive();
      test_reset();
      test_round_robin();
      test_backpressure();
      test_timeout();
      test_enable_mask();
      test_mid_reset();
      test_tlast_vs_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
